raise_freq: RTL and testbench

- Pitch-raise stage of the voice-transformer datapath, placed between the FFT and the IFFT.
- Collects one 32-bin FFT frame, then emits it with every bin moved up by SHIFT bin positions. The lowest SHIFT bins are zero-filled; bins pushed past bin 31 are discarded.
- Ping-pong buffered, so one frame is written while the previous frame is read out. Sustains one bin per clock indefinitely.

---
 rtl/raise_freq_pkg.sv | 16 +
 rtl/raise_freq_bank.sv | 35 +++
 rtl/raise_freq.sv | 108 ++++++++++
 tb/tb_raise_freq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/raise_freq_pkg.sv
// Shared types and sizes for the raise_freq pitch-raise stage.
package raise_freq_pkg;

  localparam int N_BINS = 32;
  localparam int BIN_W  = $clog2(N_BINS);
  localparam int DATA_W = 32;

  // One FFT bin: real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef logic [BIN_W-1:0] bin_idx_t;

endpackage

// File: rtl/raise_freq_bank.sv
// Ping-pong bin store for raise_freq: two banks of N_BINS complex bins.
// One synchronous write port and one combinational read port, each with its
// own bank select. Both banks are cleared by the synchronous reset.
module raise_freq_bank
  import raise_freq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_sel,
  input  bin_idx_t wr_idx,
  input  cplx_t    wr_data,
  input  logic     wr_en,
  input  logic     rd_sel,
  input  bin_idx_t rd_idx,
  output cplx_t    rd_data
);

  cplx_t mem [2][N_BINS];

  // Clear both banks on reset, otherwise store one bin per enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_BINS; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_sel][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_sel][rd_idx];

endmodule

// File: rtl/raise_freq.sv
// raise_freq: collects a 32-bin FFT frame into one bank while the previous
// frame is read from the other bank with every bin moved up by SHIFT
// positions (low bins zero-filled, bins pushed past the top discarded).
// Optional build macro RAISE_KEEP_DC_EN keeps output bin 0 equal to input
// bin 0 (DC left in place) instead of zero-filling it.
module raise_freq
  import raise_freq_pkg::*;
#(
  parameter int SHIFT = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fft1_data,
  input  logic              fft1_valid,
  input  logic [BIN_W-1:0]  freq1,
  input  logic              fft1_fin,
  output logic              raise_valid,
  output logic              raise_fin,
  output logic [DATA_W-1:0] raise_data
);

  localparam bin_idx_t SHIFT_IDX = bin_idx_t'(SHIFT);
  localparam bin_idx_t LAST_IDX  = bin_idx_t'(N_BINS - 1);

  logic     wr_bank;
  logic     rd_active;
  bin_idx_t rd_cnt;
  logic     frame_close;
  bin_idx_t rd_idx;
  cplx_t    rd_bin;
  cplx_t    bin_p0;

  // Output bin k takes input bin k-SHIFT, or zero below the shift.
  function automatic cplx_t shift_fill(input bin_idx_t k, input cplx_t bin);
`ifdef RAISE_KEEP_DC_EN
    if (k == '0) begin
      return bin;
    end
`endif
    if (k >= SHIFT_IDX) begin
      return bin;
    end
    return '0;
  endfunction

  assign frame_close = fft1_valid & fft1_fin;

  raise_freq_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_sel  (wr_bank),
    .wr_idx  (freq1),
    .wr_data (cplx_t'(fft1_data)),
    .wr_en   (fft1_valid),
    .rd_sel  (~wr_bank),
    .rd_idx  (rd_idx),
    .rd_data (rd_bin)
  );

  // Read address for output bin k; DC build pins bin 0 to input bin 0.
  always_comb begin
    rd_idx = rd_cnt - SHIFT_IDX;
`ifdef RAISE_KEEP_DC_EN
    if (rd_cnt == '0) begin
      rd_idx = '0;
    end
`endif
  end

  assign bin_p0 = shift_fill(rd_cnt, rd_bin);

  // Bank swap and read counter; a close always restarts readout at k=0,
  // even when it lands on the last bin or in the middle of a readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_active <= 1'b0;
      rd_cnt    <= '0;
    end else begin
      if (rd_active) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LAST_IDX) begin
          rd_active <= 1'b0;
        end
      end
      if (frame_close) begin
        wr_bank   <= ~wr_bank;
        rd_cnt    <= '0;
        rd_active <= 1'b1;
      end
    end
  end

  // Stage p0 -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      raise_valid <= 1'b0;
      raise_fin   <= 1'b0;
      raise_data  <= '0;
    end else begin
      raise_valid <= rd_active;
      raise_fin   <= rd_active && (rd_cnt == LAST_IDX);
      raise_data  <= rd_active ? bin_p0 : '0;
    end
  end

endmodule

// File: tb/tb_raise_freq.sv
// Directed bench for raise_freq (SHIFT=4). Builds with or without
// RAISE_KEEP_DC_EN; expectations for output bin 0 follow the build.
module tb_raise_freq;

  localparam int SHIFT = 4;
`ifdef RAISE_KEEP_DC_EN
  localparam bit KEEP_DC = 1'b1;
`else
  localparam bit KEEP_DC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] fft1_data;
  logic        fft1_valid;
  logic [4:0]  freq1;
  logic        fft1_fin;
  logic        raise_valid;
  logic        raise_fin;
  logic [31:0] raise_data;

  int n_chk = 0;
  int n_err = 0;
  int fin_cnt;

  raise_freq #(.SHIFT(SHIFT)) dut (
    .clk         (clk),
    .rst         (rst),
    .fft1_data   (fft1_data),
    .fft1_valid  (fft1_valid),
    .freq1       (freq1),
    .fft1_fin    (fft1_fin),
    .raise_valid (raise_valid),
    .raise_fin   (raise_fin),
    .raise_data  (raise_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic f, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(raise_valid), 32'(v));
    chk({tag, ".fin"}, 32'(raise_fin), 32'(f));
    chk({tag, ".data"}, raise_data, d);
  endtask

  // Input bin i of frame f; frame 0 is {i+1, -(i+1)}.
  function automatic logic [31:0] pat(input int f, input int i);
    logic [15:0] re;
    logic [15:0] im;
    re = 16'(i + 1 + f * 64);
    im = 16'(-(i + 1) - f * 3);
    return {re, im};
  endfunction

  // Expected output bin j for a fully written frame f.
  function automatic logic [31:0] exp_bin(input int f, input int j);
    if (KEEP_DC && j == 0) return pat(f, 0);
    if (j >= SHIFT) return pat(f, j - SHIFT);
    return 32'h0;
  endfunction

  task automatic step(input logic v, input int idx, input logic [31:0] d, input logic f);
    fft1_valid = v;
    freq1      = 5'(idx);
    fft1_data  = d;
    fft1_fin   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] e;
    rst        = 1'b1;
    fft1_valid = 1'b0;
    freq1      = '0;
    fft1_data  = '0;
    fft1_fin   = 1'b0;

    // 1: reset held with random inputs, then idle with a stray fin
    for (int c = 0; c < 3; c++) begin
      step(1'($urandom), int'($urandom_range(0, 31)), $urandom, 1'($urandom));
      chk_out($sformatf("rst%0d", c), 1'b0, 1'b0, 32'h0);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, c, 32'hDEAD0000, 1'b1);
      chk_out($sformatf("post_rst%0d", c), 1'b0, 1'b0, 32'h0);
    end

    // 2: single in-order frame
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i, pat(0, i), i == 31);
      chk($sformatf("s2_wr%0d.valid", i), 32'(raise_valid), 32'h0);
    end
    for (int t = 0; t < 32; t++) begin
      idle();
      chk_out($sformatf("s2_bin%0d", t), 1'b1, t == 31, exp_bin(0, t));
      if (t == 4)  chk("s2_bin4_const", raise_data, 32'h0001FFFF);
      if (t == 31) chk("s2_bin31_const", raise_data, 32'h001CFFE4);
      if (t == 0)  chk("s2_bin0_const", raise_data, KEEP_DC ? 32'h0001FFFF : 32'h0);
    end
    idle();
    chk_out("s2_end", 1'b0, 1'b0, 32'h0);

    // 4: same frame written in reverse order
    for (int i = 31; i >= 0; i--) begin
      step(1'b1, i, pat(0, i), i == 0);
    end
    for (int t = 0; t < 32; t++) begin
      idle();
      chk_out($sformatf("s4_bin%0d", t), 1'b1, t == 31, exp_bin(0, t));
    end
    idle();
    chk_out("s4_end", 1'b0, 1'b0, 32'h0);

    // 3: 16 back-to-back frames, frame g uses pattern g+1
    fin_cnt = 0;
    for (int f = 0; f <= 16; f++) begin
      for (int i = 0; i < 32; i++) begin
        if (f < 16) step(1'b1, i, pat(f + 1, i), i == 31);
        else        idle();
        if (f == 0) begin
          chk($sformatf("s3_pre%0d.valid", i), 32'(raise_valid), 32'h0);
        end else begin
          if (raise_fin) fin_cnt++;
          chk_out($sformatf("s3_f%0d_b%0d", f - 1, i), 1'b1, i == 31, exp_bin(f, i));
        end
      end
    end
    chk("s3_fin_count", 32'(fin_cnt), 32'd16);
    idle();
    chk_out("s3_end", 1'b0, 1'b0, 32'h0);

    // 5: early close of frame 2 after 10 bins while frame 1 reads out
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i, pat(20, i), i == 31);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i, pat(21, i), i == 9);
      chk_out($sformatf("s5_f1_b%0d", i), 1'b1, 1'b0, exp_bin(20, i));
    end
    for (int t = 0; t < 32; t++) begin
      idle();
      if (KEEP_DC && t == 0) e = pat(21, 0);
      else if (t < SHIFT)    e = 32'h0;
      else if (t - SHIFT < 10) e = pat(21, t - SHIFT);
      else                   e = pat(16, t - SHIFT);
      chk_out($sformatf("s5_f2_b%0d", t), 1'b1, t == 31, e);
    end
    idle();
    chk_out("s5_end", 1'b0, 1'b0, 32'h0);

    // 6: DC bin handling
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i, (i == 0) ? 32'h00640000 : pat(30, i), i == 31);
    end
    for (int t = 0; t < 32; t++) begin
      idle();
      if (t == 0)          e = KEEP_DC ? 32'h00640000 : 32'h0;
      else if (t < SHIFT)  e = 32'h0;
      else if (t == SHIFT) e = 32'h00640000;
      else                 e = pat(30, t - SHIFT);
      chk_out($sformatf("s6_bin%0d", t), 1'b1, t == 31, e);
    end
    idle();

    // 7: reset in the middle of a readout aborts it without fin
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i, pat(40, i), i == 31);
    end
    for (int t = 0; t < 10; t++) idle();
    chk("s7_midread.valid", 32'(raise_valid), 32'h1);
    rst = 1'b1;
    idle();
    chk_out("s7_rst", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      idle();
      chk_out($sformatf("s7_after%0d", t), 1'b0, 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
